// File: rtl/rv32i_sc_core_pkg.sv
// Shared configuration, opcode constants and control encodings for the single-cycle RV32I core.
package rv32i_sc_core_pkg;

    localparam int          IMEM_WORDS_DEFAULT = 1024;
    localparam int          DMEM_WORDS_DEFAULT = 1024;
    localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h5000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [1:0] { MEM_BYTE, MEM_HALF, MEM_WORD } mem_width_e;
    typedef enum logic [1:0] { WB_ALU, WB_MEM, WB_PC4 } wb_sel_e;
    typedef enum logic [1:0] { PC_PLUS4, PC_BRANCH, PC_JUMP } pc_sel_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       a_is_pc;
        logic       b_is_imm;
        wb_sel_e    wb_sel;
        pc_sel_e    pc_sel;
        logic       reg_we;
        logic       mem_we;
        mem_width_e mem_width;
        logic       mem_sext;
    } ctrl_t;

    // alt selects SUB for funct3=000 and the arithmetic shift for funct3=101
    function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        unique case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_sc_core_alu.sv
// Combinational RV32I integer ALU.
module rv32i_sc_core_alu
    import rv32i_sc_core_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res
);

    always_comb begin
        res = 32'd0;
        unique case (op)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_SLL:   res = a << b[4:0];
            ALU_SLT:   res = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  res = {31'd0, a < b};
            ALU_XOR:   res = a ^ b;
            ALU_SRL:   res = a >> b[4:0];
            ALU_SRA:   res = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:    res = a | b;
            ALU_AND:   res = a & b;
            ALU_PASSB: res = b;
            default:   res = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32i_sc_core_decoder.sv
// Instruction decoder: turns one RV32I instruction word into control signals and its immediate.
module rv32i_sc_core_decoder
    import rv32i_sc_core_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [31:0] imm
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Anything not recognised falls through with the NOP defaults: pc+4 and no writes
    always_comb begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.a_is_pc   = 1'b0;
        ctrl.b_is_imm  = 1'b0;
        ctrl.wb_sel    = WB_ALU;
        ctrl.pc_sel    = PC_PLUS4;
        ctrl.reg_we    = 1'b0;
        ctrl.mem_we    = 1'b0;
        ctrl.mem_width = MEM_WORD;
        ctrl.mem_sext  = 1'b0;
        imm            = 32'd0;
        unique case (opcode)
            OPC_LUI: begin
                ctrl.alu_op   = ALU_PASSB;
                ctrl.b_is_imm = 1'b1;
                ctrl.reg_we   = 1'b1;
                imm           = imm_u;
            end
            OPC_AUIPC: begin
                ctrl.a_is_pc  = 1'b1;
                ctrl.b_is_imm = 1'b1;
                ctrl.reg_we   = 1'b1;
                imm           = imm_u;
            end
            OPC_JAL: begin
                ctrl.a_is_pc  = 1'b1;
                ctrl.b_is_imm = 1'b1;
                ctrl.wb_sel   = WB_PC4;
                ctrl.pc_sel   = PC_JUMP;
                ctrl.reg_we   = 1'b1;
                imm           = imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    ctrl.b_is_imm = 1'b1;
                    ctrl.wb_sel   = WB_PC4;
                    ctrl.pc_sel   = PC_JUMP;
                    ctrl.reg_we   = 1'b1;
                    imm           = imm_i;
                end
            end
            OPC_BRANCH: begin
                // The ALU forms the target; the taken decision is made by the top-level comparator
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    ctrl.a_is_pc  = 1'b1;
                    ctrl.b_is_imm = 1'b1;
                    ctrl.pc_sel   = PC_BRANCH;
                    imm           = imm_b;
                end
            end
            OPC_LOAD: begin
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
                    ctrl.b_is_imm  = 1'b1;
                    ctrl.wb_sel    = WB_MEM;
                    ctrl.reg_we    = 1'b1;
                    ctrl.mem_sext  = ~funct3[2];
                    ctrl.mem_width = (funct3[1:0] == 2'b00) ? MEM_BYTE :
                                     (funct3[1:0] == 2'b01) ? MEM_HALF : MEM_WORD;
                    imm            = imm_i;
                end
            end
            OPC_STORE: begin
                if (funct3[2] == 1'b0 && funct3[1:0] != 2'b11) begin
                    ctrl.b_is_imm  = 1'b1;
                    ctrl.mem_we    = 1'b1;
                    ctrl.mem_width = (funct3[1:0] == 2'b00) ? MEM_BYTE :
                                     (funct3[1:0] == 2'b01) ? MEM_HALF : MEM_WORD;
                    imm            = imm_s;
                end
            end
            OPC_OPIMM: begin
                ctrl.alu_op   = alu_op_from_funct(funct3, (funct3 == 3'b101) & instr[30]);
                ctrl.b_is_imm = 1'b1;
                ctrl.reg_we   = 1'b1;
                imm           = imm_i;
            end
            OPC_OP: begin
                ctrl.alu_op = alu_op_from_funct(funct3, instr[30]);
                ctrl.reg_we = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_sc_core_dmem.sv
// Little-endian data memory: combinational lane-selecting load, byte-masked store at the clock edge.
module rv32i_sc_core_dmem
    import rv32i_sc_core_pkg::*;
#(
    parameter int          WORDS = 1024,
    parameter logic [31:0] BASE  = 32'h5000_0000
) (
    input  logic        clk,
    input  logic [31:0] address,
    input  mem_width_e  width,
    input  logic        sign_extend,
    input  logic        write_enable,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem [0:WORDS-1];
    logic [31:0]   offset;
    logic [AW-1:0] index;
    logic [1:0]    lane;
    logic [31:0]   word;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    logic [3:0]    byte_en;
    logic [31:0]   wdata;
    logic          unused_offset_hi;

    // Upper offset bits are dropped so any address aliases into the window
    assign offset           = address - BASE;
    assign index            = offset[AW+1:2];
    assign lane             = offset[1:0];
    assign unused_offset_hi = ^offset[31:AW+2];
    assign word             = mem[index];
    assign byte_val         = word[{lane, 3'b000} +: 8];
    assign half_val         = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        data_out = word;
        unique case (width)
            MEM_BYTE: data_out = {{24{sign_extend & byte_val[7]}}, byte_val};
            MEM_HALF: data_out = {{16{sign_extend & half_val[15]}}, half_val};
            default:  data_out = word;
        endcase
    end

    // Store data is replicated across lanes so the byte-enable mask alone picks the target bytes
    always_comb begin
        byte_en = 4'b1111;
        wdata   = data_in;
        unique case (width)
            MEM_BYTE: begin
                byte_en = 4'b0001 << lane;
                wdata   = {4{data_in[7:0]}};
            end
            MEM_HALF: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{data_in[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wdata   = data_in;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (write_enable) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/rv32i_sc_core_imem.sv
// Instruction memory with combinational fetch; the load port lets a loader fill it, normally tied off.
module rv32i_sc_core_imem #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [31:0]   data
);

    logic [31:0] mem [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (load_we) mem[load_addr] <= load_data;
    end

    assign data = mem[addr];

endmodule

// File: rtl/rv32i_sc_core_rf.sv
// 32 x 32-bit register file, two combinational read ports, one write port; x0 is hardwired to zero.
module rv32i_sc_core_rf (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (we && rd_addr != 5'd0) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

endmodule

// File: rtl/rv32i_sc_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback all complete in one clock.
module rv32i_sc_core
    import rv32i_sc_core_pkg::*;
#(
    parameter int          IMEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter int          DMEM_WORDS = DMEM_WORDS_DEFAULT,
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT
) (
    input logic clk,
    input logic reset
);

    localparam int IMEM_AW = $clog2(IMEM_WORDS);

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] instr, imm;
    logic [31:0] rs1_val, rs2_val, alu_a, alu_b, alu_res;
    logic [31:0] load_data, wb_data;
    logic [2:0]  funct3;
    logic        br_taken;
    ctrl_t       ctrl;

    assign funct3   = instr[14:12];
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= 32'd0;
        else        pc_q <= pc_d;
    end

    rv32i_sc_core_imem #(.WORDS(IMEM_WORDS)) imem (
        .clk       (clk),
        .addr      (pc_q[IMEM_AW+1:2]),
        .load_we   (1'b0),
        .load_addr ('0),
        .load_data (32'd0),
        .data      (instr)
    );

    rv32i_sc_core_decoder decoder (
        .instr (instr),
        .ctrl  (ctrl),
        .imm   (imm)
    );

    rv32i_sc_core_rf rf (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (instr[19:15]),
        .rs2_addr (instr[24:20]),
        .we       (ctrl.reg_we),
        .rd_addr  (instr[11:7]),
        .rd_data  (wb_data),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val)
    );

    assign alu_a = ctrl.a_is_pc  ? pc_q : rs1_val;
    assign alu_b = ctrl.b_is_imm ? imm  : rs2_val;

    rv32i_sc_core_alu alu (
        .op  (ctrl.alu_op),
        .a   (alu_a),
        .b   (alu_b),
        .res (alu_res)
    );

    rv32i_sc_core_dmem #(.WORDS(DMEM_WORDS), .BASE(DMEM_BASE)) dmem (
        .clk          (clk),
        .address      (alu_res),
        .width        (ctrl.mem_width),
        .sign_extend  (ctrl.mem_sext),
        .write_enable (ctrl.mem_we),
        .data_in      (rs2_val),
        .data_out     (load_data)
    );

    always_comb begin
        br_taken = 1'b0;
        unique case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        wb_data = alu_res;
        unique case (ctrl.wb_sel)
            WB_MEM:  wb_data = load_data;
            WB_PC4:  wb_data = pc_plus4;
            default: wb_data = alu_res;
        endcase
    end

    // JAL targets are already even, so clearing bit 0 only matters for JALR
    always_comb begin
        pc_d = pc_plus4;
        unique case (ctrl.pc_sel)
            PC_BRANCH: pc_d = br_taken ? alu_res : pc_plus4;
            PC_JUMP:   pc_d = {alu_res[31:1], 1'b0};
            default:   pc_d = pc_plus4;
        endcase
    end

endmodule

// File: tb/tb_rv32i_sc_core.sv
// Directed bench for rv32i_sc_core: backdoor-loaded program, scoreboard of expected PC/register/memory state.
module tb_rv32i_sc_core;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    localparam int K_PC  = 0;
    localparam int K_REG = 1;
    localparam int K_MEM = 2;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb_q[$];
    int   tests_run;
    int   tests_failed;

    rv32i_sc_core dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction encoders, built from the RV32I field layout
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [31:0] imm);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [31:0] imm20);
        return {imm20[19:0], rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic put(input int pc, input logic [31:0] word);
        dut.imem.mem[pc / 4] = word;
    endtask

    task automatic expect_val(input string tag, input int kind, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    // Advances n clock cycles; returns on a falling edge so outputs are stable
    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.kind == K_PC)       obs = dut.pc_q;
            else if (e.kind == K_REG) obs = dut.rf.regs[e.idx];
            else                      obs = dut.dmem.mem[e.idx];
            tests_run++;
            assert (obs === e.exp) else begin
                tests_failed++;
                $error("[TB] FAIL %s: observed %08h expected %08h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;

        for (int i = 0; i < 1024; i++) dut.imem.mem[i] = 32'h0000_0013;
        put(0,   enc_u(OP_AUIPC, 5'd2, 32'h50000));
        put(4,   enc_i(OP_IMM, 5'd2, 3'd0, 5'd2, 32'h500));
        put(8,   enc_u(OP_AUIPC, 5'd10, 32'h50000));
        put(12,  enc_i(OP_IMM, 5'd10, 3'd0, 5'd10, -8));
        put(16,  enc_i(OP_LOAD, 5'd5,  3'd0, 5'd10, 0));
        put(20,  enc_i(OP_LOAD, 5'd6,  3'd0, 5'd10, 1));
        put(24,  enc_i(OP_LOAD, 5'd7,  3'd0, 5'd10, 2));
        put(28,  enc_i(OP_LOAD, 5'd28, 3'd0, 5'd10, 3));
        put(32,  enc_i(OP_LOAD, 5'd29, 3'd1, 5'd10, 0));
        put(36,  enc_i(OP_LOAD, 5'd30, 3'd1, 5'd10, 2));
        put(40,  enc_i(OP_LOAD, 5'd31, 3'd2, 5'd10, 0));
        put(44,  enc_i(OP_LOAD, 5'd8,  3'd4, 5'd10, 0));
        put(48,  enc_i(OP_LOAD, 5'd9,  3'd4, 5'd10, 1));
        put(52,  enc_i(OP_LOAD, 5'd11, 3'd4, 5'd10, 2));
        put(56,  enc_i(OP_LOAD, 5'd12, 3'd4, 5'd10, 3));
        put(60,  enc_i(OP_LOAD, 5'd13, 3'd5, 5'd10, 0));
        put(64,  enc_i(OP_LOAD, 5'd14, 3'd5, 5'd10, 2));
        put(68,  enc_s(3'd0, 5'd10, 5'd5,  4));
        put(72,  enc_s(3'd0, 5'd10, 5'd6,  5));
        put(76,  enc_s(3'd0, 5'd10, 5'd7,  6));
        put(80,  enc_s(3'd0, 5'd10, 5'd28, 7));
        put(84,  enc_s(3'd1, 5'd10, 5'd29, 8));
        put(88,  enc_s(3'd1, 5'd10, 5'd30, 10));
        put(92,  enc_u(OP_LUI, 5'd15, 32'h80000));
        put(96,  enc_i(OP_IMM, 5'd16, 3'd0, 5'd0, 4));
        put(100, enc_r(7'b0100000, 5'd16, 5'd15, 3'd5, 5'd17));
        put(104, enc_r(7'b0100000, 5'd16, 5'd15, 3'd0, 5'd18));
        put(108, enc_i(OP_IMM, 5'd19, 3'd0, 5'd0, 1));
        put(112, enc_i(OP_IMM, 5'd20, 3'd0, 5'd0, -1));
        put(116, enc_r(7'b0000000, 5'd20, 5'd19, 3'd3, 5'd21));
        put(120, enc_b(3'd0, 5'd19, 5'd19, 8));
        put(124, enc_i(OP_IMM, 5'd22, 3'd0, 5'd0, 32'h7FF));
        put(128, enc_b(3'd0, 5'd19, 5'd20, 8));
        put(132, enc_i(OP_IMM, 5'd23, 3'd0, 5'd0, 5));
        put(136, enc_j(5'd1, 8));
        put(140, enc_i(OP_IMM, 5'd24, 3'd0, 5'd0, 9));
        put(144, enc_i(OP_IMM, 5'd25, 3'd0, 5'd0, 164));
        put(148, enc_i(OP_JALR, 5'd26, 3'd0, 5'd25, 1));
        put(152, enc_i(OP_IMM, 5'd27, 3'd0, 5'd0, 1));
        put(164, enc_i(OP_IMM, 5'd0, 3'd0, 5'd0, 5));
        put(168, 32'h0000_0073);
        put(172, enc_j(5'd0, 0));

        dut.dmem.mem[0] = 32'hF4F3_F201;
        dut.dmem.mem[1] = 32'h0102_0304;
        dut.dmem.mem[2] = 32'h1234_5678;
        dut.dmem.mem[3] = 32'hF1F2_F3F4;

        #1 reset = 1'b0;
        applyStimulus(2);
        expect_val("reset_pc", K_PC, 0, 32'd0);
        expect_val("reset_sp", K_REG, 2, 32'd0);
        checkOutput();

        reset = 1'b1;
        applyStimulus(4);
        expect_val("setup_pc", K_PC, 0, 32'd16);
        expect_val("sp", K_REG, 2, 32'h5000_0500);
        expect_val("a0", K_REG, 10, 32'h5000_0000);
        checkOutput();

        applyStimulus(7);
        expect_val("lb_t0", K_REG, 5,  32'h0000_0001);
        expect_val("lb_t1", K_REG, 6,  32'hFFFF_FFF2);
        expect_val("lb_t2", K_REG, 7,  32'hFFFF_FFF3);
        expect_val("lb_t3", K_REG, 28, 32'hFFFF_FFF4);
        expect_val("lh_t4", K_REG, 29, 32'hFFFF_F201);
        expect_val("lh_t5", K_REG, 30, 32'hFFFF_F4F3);
        expect_val("lw_t6", K_REG, 31, 32'hF4F3_F201);
        checkOutput();

        applyStimulus(6);
        expect_val("lbu_0", K_REG, 8,  32'h0000_0001);
        expect_val("lbu_1", K_REG, 9,  32'h0000_00F2);
        expect_val("lbu_2", K_REG, 11, 32'h0000_00F3);
        expect_val("lbu_3", K_REG, 12, 32'h0000_00F4);
        expect_val("lhu_0", K_REG, 13, 32'h0000_F201);
        expect_val("lhu_2", K_REG, 14, 32'h0000_F4F3);
        checkOutput();

        applyStimulus(6);
        expect_val("store_pc", K_PC, 0, 32'd92);
        expect_val("mem0", K_MEM, 0, 32'hF4F3_F201);
        expect_val("mem1_sb", K_MEM, 1, 32'hF4F3_F201);
        expect_val("mem2_sh", K_MEM, 2, 32'hF4F3_F201);
        expect_val("mem3", K_MEM, 3, 32'hF1F2_F3F4);
        checkOutput();

        applyStimulus(7);
        expect_val("sra", K_REG, 17, 32'hF800_0000);
        expect_val("sub", K_REG, 18, 32'h7FFF_FFFC);
        expect_val("sltu", K_REG, 21, 32'd1);
        expect_val("pre_beq_pc", K_PC, 0, 32'd120);
        checkOutput();

        applyStimulus(1);
        expect_val("beq_taken_pc", K_PC, 0, 32'd128);
        checkOutput();
        applyStimulus(1);
        expect_val("beq_not_taken_pc", K_PC, 0, 32'd132);
        checkOutput();
        applyStimulus(2);
        expect_val("jal_pc", K_PC, 0, 32'd144);
        expect_val("jal_link", K_REG, 1, 32'd140);
        expect_val("after_not_taken", K_REG, 23, 32'd5);
        checkOutput();
        applyStimulus(2);
        expect_val("jalr_pc", K_PC, 0, 32'd164);
        expect_val("jalr_link", K_REG, 26, 32'd152);
        checkOutput();

        applyStimulus(2);
        expect_val("jloop_pc", K_PC, 0, 32'd172);
        expect_val("x0_zero", K_REG, 0, 32'd0);
        expect_val("beq_skipped", K_REG, 22, 32'd0);
        expect_val("jal_skipped", K_REG, 24, 32'd0);
        expect_val("jalr_skipped", K_REG, 27, 32'd0);
        checkOutput();

        for (int c = 0; c < 6; c++) begin
            applyStimulus(1);
            expect_val($sformatf("jloop_hold_%0d", c), K_PC, 0, 32'd172);
            checkOutput();
        end
        expect_val("jloop_mem1", K_MEM, 1, 32'hF4F3_F201);
        checkOutput();

        #2 reset = 1'b0;
        #1;
        expect_val("async_reset_pc", K_PC, 0, 32'd0);
        expect_val("async_reset_sp", K_REG, 2, 32'd0);
        expect_val("async_reset_t6", K_REG, 31, 32'd0);
        expect_val("async_reset_mem1", K_MEM, 1, 32'hF4F3_F201);
        checkOutput();

        @(negedge clk);
        reset = 1'b1;
        applyStimulus(4);
        expect_val("restart_pc", K_PC, 0, 32'd16);
        expect_val("restart_sp", K_REG, 2, 32'h5000_0500);
        expect_val("restart_a0", K_REG, 10, 32'h5000_0000);
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
